// File: rtl/retro_sram_wait_sequencer.sv
// retro_sram_wait_sequencer
//
// Multi-cycle access sequencer placed directly in front of the SRAM controller.
// It takes one request from the initiator and holds address, write data and
// write strobe stable toward the controller for WaitStates+1 cycles. This lets
// slow asynchronous SRAM work behind a controller that always reports ready.
// Read data comes back through a registered Dout, together with a one-cycle
// DataReady pulse.
//
// Optional build macro:
//   RETRO_SRAM_WRITE_TURNAROUND_EN - after each write, spend one RECOVER cycle
//                                    (Ready=0, TAccess=0) for bus turnaround.
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-high reset
//   Access     in   initiator request valid
//   Write      in   initiator request is a write
//   Address    in   initiator word address
//   Din        in   initiator write data
//   Dout       out  read data of the last completed read
//   Ready      out  request accepted this cycle if Access is high
//   DataReady  out  one-cycle pulse: Dout holds fresh read data
//   TAccess    out  access strobe to SRAM controller
//   TWrite     out  write strobe to SRAM controller
//   TAddress   out  address to SRAM controller
//   TDout      out  write data to SRAM controller
//   TDin       in   read data from SRAM controller

module retro_sram_wait_sequencer #(
    parameter int unsigned AddressBusWidth = 16,
    parameter int unsigned DataBusWidth    = 1,
    parameter int unsigned WaitStates      = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Access,
    input  logic                         Write,
    input  logic [AddressBusWidth-1:0]   Address,
    input  logic [8*DataBusWidth-1:0]    Din,
    output logic [8*DataBusWidth-1:0]    Dout,
    output logic                         Ready,
    output logic                         DataReady,
    output logic                         TAccess,
    output logic                         TWrite,
    output logic [AddressBusWidth-1:0]   TAddress,
    output logic [8*DataBusWidth-1:0]    TDout,
    input  logic [8*DataBusWidth-1:0]    TDin
);

    localparam int unsigned DataWidth = 8 * DataBusWidth;
    localparam int unsigned CntWidth  = (WaitStates == 0) ? 1 : $clog2(WaitStates + 1);

`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;
`else
    typedef enum logic [0:0] {StIdle, StAccess} state_e;
`endif

    state_e                       state_q, state_d;
    logic [CntWidth-1:0]          cnt_q, cnt_d;
    logic                         taccess_q, taccess_d;
    logic                         twrite_q, twrite_d;
    logic [AddressBusWidth-1:0]   taddress_q, taddress_d;
    logic [DataWidth-1:0]         tdout_q, tdout_d;
    logic [DataWidth-1:0]         dout_q, dout_d;
    logic                         data_ready_q, data_ready_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            taccess_q    <= 1'b0;
            twrite_q     <= 1'b0;
            taddress_q   <= '0;
            tdout_q      <= '0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            taccess_q    <= taccess_d;
            twrite_q     <= twrite_d;
            taddress_q   <= taddress_d;
            tdout_q      <= tdout_d;
            dout_q       <= dout_d;
            data_ready_q <= data_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        taccess_d    = taccess_q;
        twrite_d     = twrite_q;
        taddress_d   = taddress_q;
        tdout_d      = tdout_q;
        dout_d       = dout_q;
        data_ready_d = 1'b0;
        Ready        = 1'b0;

        case (state_q)
            StIdle: begin
                Ready = 1'b1;
                if (Access) begin
                    taddress_d = Address;
                    tdout_d    = Din;
                    twrite_d   = Write;
                    taccess_d  = 1'b1;
                    cnt_d      = CntWidth'(WaitStates);
                    state_d    = StAccess;
                end
            end

            StAccess: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Last held cycle: release the bus on this edge.
                    taccess_d = 1'b0;
                    twrite_d  = 1'b0;
                    if (!twrite_q) begin
                        dout_d       = TDin;
                        data_ready_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
                        state_d = StRecover;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end

`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
            StRecover: begin
                state_d = StIdle;
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign TAccess   = taccess_q;
    assign TWrite    = twrite_q;
    assign TAddress  = taddress_q;
    assign TDout     = tdout_q;
    assign Dout      = dout_q;
    assign DataReady = data_ready_q;

endmodule

// File: tb/tb_retro_sram_wait_sequencer.sv
// Directed self-checking bench for retro_sram_wait_sequencer.
// dut uses WaitStates=2, dut0 uses WaitStates=0; both share clock and reset.

module tb_retro_sram_wait_sequencer;

    logic        clk;
    logic        reset;
    logic        access, write;
    logic [15:0] address;
    logic [7:0]  din, tdin;
    logic [7:0]  dout, tdout;
    logic        ready, data_ready, taccess, twrite;
    logic [15:0] taddress;

    logic        access0;
    logic [15:0] address0;
    logic [7:0]  tdin0, dout0, tdout0;
    logic        ready0, data_ready0, taccess0, twrite0;
    logic [15:0] taddress0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int starts[$];
    logic ta_prev = 1'b0;

    int   n;
    int   gap;
    logic ok;

    retro_sram_wait_sequencer #(
        .AddressBusWidth(16),
        .DataBusWidth   (1),
        .WaitStates     (2)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Access   (access),
        .Write    (write),
        .Address  (address),
        .Din      (din),
        .Dout     (dout),
        .Ready    (ready),
        .DataReady(data_ready),
        .TAccess  (taccess),
        .TWrite   (twrite),
        .TAddress (taddress),
        .TDout    (tdout),
        .TDin     (tdin)
    );

    retro_sram_wait_sequencer #(
        .AddressBusWidth(16),
        .DataBusWidth   (1),
        .WaitStates     (0)
    ) dut0 (
        .Clk      (clk),
        .Reset    (reset),
        .Access   (access0),
        .Write    (1'b0),
        .Address  (address0),
        .Din      (8'h00),
        .Dout     (dout0),
        .Ready    (ready0),
        .DataReady(data_ready0),
        .TAccess  (taccess0),
        .TWrite   (twrite0),
        .TAddress (taddress0),
        .TDout    (tdout0),
        .TDin     (tdin0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record the cycle of every TAccess rising edge of the main DUT.
    always @(negedge clk) begin
        if (taccess && !ta_prev) starts.push_back(cyc);
        ta_prev = taccess;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic last_gap(output int g);
        if (starts.size() >= 2) g = starts[starts.size()-1] - starts[starts.size()-2];
        else g = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; access = 1'b1; write = 1'b1; address = 16'hAAAA; din = 8'h55;
        tdin = 8'h00; access0 = 1'b1; address0 = 16'h0000; tdin0 = 8'h00;

        // Reset held with Access asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_taccess", taccess, 0);
            check("rst_twrite", twrite, 0);
            check("rst_dready", data_ready, 0);
            check("rst_ready", ready, 1);
            check("rst_dout", dout, 8'h00);
        end
        access = 1'b0; write = 1'b0; access0 = 1'b0; reset = 1'b0;
        tick();
        check("idle_ready", ready, 1);

        // Read 0x1234 -> 0xA5.
        access = 1'b1; write = 1'b0; address = 16'h1234; tdin = 8'hA5;
        tick();
        access = 1'b0;
        check("rd_busy", ready, 0);
        n = 0; ok = 1'b1;
        while (taccess === 1'b1 && n < 20) begin
            if (taddress !== 16'h1234) ok = 1'b0;
            n++;
            tick();
        end
        check("rd_hold", n, 3);
        check("rd_addr", ok, 1);
        check("rd_dready", data_ready, 1);
        check("rd_dout", dout, 8'hA5);
        check("rd_ready", ready, 1);
        tick();
        check("rd_pulse", data_ready, 0);
        check("rd_dout_hold", dout, 8'hA5);

        // Write 0xBEEF <- 0x3C.
        access = 1'b1; write = 1'b1; address = 16'hBEEF; din = 8'h3C; tdin = 8'h5A;
        tick();
        access = 1'b0;
        n = 0; ok = 1'b1;
        while (taccess === 1'b1 && n < 20) begin
            if (twrite !== 1'b1 || tdout !== 8'h3C || taddress !== 16'hBEEF
                || data_ready !== 1'b0) ok = 1'b0;
            n++;
            tick();
        end
        check("wr_hold", n, 3);
        check("wr_stable", ok, 1);
        check("wr_dready", data_ready, 0);
        check("wr_dout", dout, 8'hA5);
        check("wr_twrite_end", twrite, 0);
`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
        check("wr_recover_ready", ready, 0);
`else
        check("wr_end_ready", ready, 1);
`endif
        tick();
        check("wr_idle_ready", ready, 1);

        // Back-to-back read then write, with address change during ACCESS.
        access = 1'b1; write = 1'b0; address = 16'h0001; tdin = 8'h11;
        tick();
        address = 16'hFFFF;
        check("b2b_addr0", taddress, 16'h0001);
        tick();
        check("b2b_addr1", taddress, 16'h0001);
        tick();
        check("b2b_addr2", taddress, 16'h0001);
        address = 16'h0002; write = 1'b1; din = 8'hC3;
        tick();
        check("b2b_dready", data_ready, 1);
        check("b2b_dout", dout, 8'h11);
        check("b2b_gapcyc", taccess, 0);
        tick();
        access = 1'b0;
        check("b2b_2nd_taccess", taccess, 1);
        check("b2b_2nd_addr", taddress, 16'h0002);
        check("b2b_2nd_twrite", twrite, 1);
        check("b2b_2nd_tdout", tdout, 8'hC3);
        tick();
        last_gap(gap);
        check("b2b_spacing", gap, 4);
        n = 0;
        while (taccess === 1'b1 && n < 20) begin n++; tick(); end
        tick();
        tick();

        // WaitStates = 0 instance.
        access0 = 1'b1; address0 = 16'h0010; tdin0 = 8'h77;
        tick();
        access0 = 1'b0;
        check("ws0_taccess", taccess0, 1);
        check("ws0_addr", taddress0, 16'h0010);
        tick();
        check("ws0_taccess_end", taccess0, 0);
        check("ws0_dready", data_ready0, 1);
        check("ws0_dout", dout0, 8'h77);
        tick();
        check("ws0_pulse", data_ready0, 0);

        // Reset during the 2nd ACCESS cycle of a read.
        access = 1'b1; write = 1'b0; address = 16'h4321; tdin = 8'h99;
        tick();
        access = 1'b0;
        tick();
        check("mid_taccess_pre", taccess, 1);
        reset = 1'b1;
        #1;
        check("mid_taccess_async", taccess, 0);
        check("mid_ready", ready, 1);
        tick();
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (data_ready !== 1'b0 || taccess !== 1'b0) ok = 1'b0;
            tick();
        end
        check("mid_no_dready", ok, 1);
        check("mid_dout_rst", dout, 8'h00);
        access = 1'b1; write = 1'b0; address = 16'h0055; tdin = 8'h66;
        tick();
        access = 1'b0;
        n = 0;
        while (taccess === 1'b1 && n < 20) begin n++; tick(); end
        check("post_rst_hold", n, 3);
        check("post_rst_dready", data_ready, 1);
        check("post_rst_dout", dout, 8'h66);
        tick();

        // Write followed by a held read.
        access = 1'b1; write = 1'b1; address = 16'h0100; din = 8'hAA;
        tick();
        write = 1'b0; address = 16'h0200; tdin = 8'hBB;
        tick();
        tick();
        tick();
        check("ta_gap_taccess", taccess, 0);
`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
        check("ta_gap_ready", ready, 0);
`else
        check("ta_gap_ready", ready, 1);
`endif
        n = 0;
        while (taccess !== 1'b1 && n < 10) begin n++; tick(); end
        access = 1'b0;
        check("ta_read_addr", taddress, 16'h0200);
        tick();
        last_gap(gap);
`ifdef RETRO_SRAM_WRITE_TURNAROUND_EN
        check("ta_spacing", gap, 5);
`else
        check("ta_spacing", gap, 4);
`endif
        n = 0;
        while (taccess === 1'b1 && n < 20) begin n++; tick(); end
        check("ta_read_dout", dout, 8'hBB);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retro_sram_wait_sequencer.md
Name: retro_sram_wait_sequencer

Overview:
- Multi-cycle access sequencer that sits directly upstream of the SRAM controller block.
- Accepts single-port memory requests from an initiator (CPU/DMA side) and holds address, write data and write strobe stable toward the SRAM controller for a programmable number of wait states.
- Returns read data with a registered DataReady pulse.
- Makes slow asynchronous SRAM usable behind the controller, which itself reports always-ready.

Parameters:
- AddressBusWidth, 16, address width in words.
- DataBusWidth, 1, data width in bytes (data buses are 8*DataBusWidth bits).
- WaitStates, 2, extra cycles an access is held beyond the first; legal range 0..15.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Access  input  1  initiator request valid.
- Write  input  1  initiator request is a write (qualified by Access).
- Address  input  AddressBusWidth  initiator address.
- Din  input  8*DataBusWidth  initiator write data.
- Dout  output  8*DataBusWidth  read data returned to initiator.
- Ready  output  1  sequencer can accept a request this cycle.
- DataReady  output  1  one-cycle pulse: Dout holds data of the just-completed read.
- TAccess  output  1  access strobe to SRAM controller.
- TWrite  output  1  write strobe to SRAM controller.
- TAddress  output  AddressBusWidth  address to SRAM controller.
- TDout  output  8*DataBusWidth  write data to SRAM controller.
- TDin  input  8*DataBusWidth  read data from SRAM controller.

Behaviour:
- Outputs are all registered except Ready, which is decoded from state.
- Reset values: state IDLE; counter 0; TAccess, TWrite, DataReady = 0; TAddress, TDout, Dout = 0; Ready = 1.
- States: IDLE, ACCESS, RECOVER (RECOVER exists only with the optional feature).
- IDLE:
  - Ready = 1; TAccess = 0; TWrite = 0.
  - Acceptance is Access && Ready at a rising edge.
  - On acceptance: latch Address→TAddress, Din→TDout, Write→TWrite; TAccess←1; counter←WaitStates; state←ACCESS.
- ACCESS:
  - Ready = 0.
  - TAccess, TWrite, TAddress and TDout hold constant for exactly WaitStates+1 cycles.
  - Counter decrements each cycle while nonzero.
- Last ACCESS cycle (counter == 0), at the ending edge:
  - TAccess←0, TWrite←0, state←IDLE.
  - If read: Dout←TDin, DataReady←1.
  - If write: Dout unchanged, DataReady stays 0.
- DataReady is high for exactly one cycle: the first IDLE cycle after a read.
- Dout holds its value until the next read completes.
- Read latency: accepted at edge E; DataReady high in the cycle after edge E+WaitStates+1.
- Throughput: one access per WaitStates+2 cycles.
- Back-to-back: Access held high in the IDLE cycle in which DataReady = 1 is accepted normally.
- Requests while Ready = 0 are ignored, not queued; the initiator must hold Access until Ready.
- Initiator input changes during ACCESS have no effect on T* outputs.
- WaitStates = 0: ACCESS lasts one cycle.
- Counter width is max(1, $clog2(WaitStates+1)). There is no wrap-around: the counter never decrements below 0.
- Reset asserted mid-access: TAccess and TWrite drop asynchronously, the transaction is abandoned, no DataReady, and the state is IDLE after Reset deasserts.

Optional Feature:
- Macro: RETRO_SRAM_WRITE_TURNAROUND_EN.
- Defined:
  - After a write's last ACCESS cycle the state goes to RECOVER for exactly one cycle: Ready = 0, TAccess = 0, TWrite = 0; then IDLE.
  - This gives bus turnaround before a following read.
  - Write throughput becomes WaitStates+3 cycles; reads are unaffected.
- Not defined: RECOVER is absent, and writes return directly to IDLE as above.

Test Plan (AddressBusWidth=16, DataBusWidth=1, WaitStates=2 unless noted):
- Reset: assert Reset with Access=1 → TAccess=0, TWrite=0, DataReady=0, Ready=1, Dout=8'h00 throughout.
- Read: Access=1, Write=0, Address=16'h1234 for one cycle, TDin=8'hA5 → TAccess=1, TAddress=16'h1234 for exactly 3 cycles; then DataReady=1 for 1 cycle with Dout=8'hA5; Ready=1 that same cycle.
- Write: Address=16'hBEEF, Din=8'h3C → TWrite=1, TAccess=1, TDout=8'h3C for exactly 3 cycles; DataReady stays 0; Dout unchanged.
- Back-to-back and input change: Access held high with a read to 16'h0001 then a write to 16'h0002; change Address to 16'hFFFF during ACCESS → TAddress stays 16'h0001; second access begins on the IDLE cycle; accesses are 4 cycles apart.
- WaitStates=0: read to 16'h0010, TDin=8'h77 → TAccess=1 for 1 cycle; DataReady with Dout=8'h77 on the next cycle.
- Reset mid-read on the 2nd ACCESS cycle → TAccess drops asynchronously; no DataReady pulse; next request after reset completes normally. With RETRO_SRAM_WRITE_TURNAROUND_EN: a write followed by a held read shows a 1-cycle Ready=0, TAccess=0 gap, 5 cycles between accepts.
